// File: rtl/stage_execute_pkg.sv
// stage_execute_pkg: shared types, bubble constant and single-cycle ALU for the execute stage.
package stage_execute_pkg;
  typedef logic [31:0] V32;
  typedef enum logic [3:0] {NOP, ADD, SUB, AND, OR, XOR, SHL, SHR, RDL, WRL, MUL, DIV} t_operation;
  typedef struct packed {
    t_operation operation;
    V32 v1;
    V32 v2;
    V32 result;
  } t_stage;
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} t_state;
  localparam t_stage BUBBLE = '0;
  function automatic logic is_muldiv(input t_operation op);
    return op == MUL || op == DIV;
  endfunction
  // RDL/WRL/NOP and the iterative ops yield 0 here.
  function automatic V32 alu(input t_operation op, input V32 a, input V32 b);
    return op == ADD ? a + b :
           op == SUB ? a - b :
           op == AND ? a & b :
           op == OR  ? a | b :
           op == XOR ? a ^ b :
           op == SHL ? a << b[4:0] :
           op == SHR ? a >> b[4:0] : '0;
  endfunction
endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv: radix-2 shift-add multiplier / restoring divider, 32 steps after start.
module iter_muldiv
  import stage_execute_pkg::*;
#(
  parameter V32 DIV_ZERO_RESULT = 32'hFFFF_FFFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  t_operation op,
  input  V32         a,
  input  V32         b,
  output logic       done,
  output V32         result
);
  logic r_run, r_div;
  logic [4:0] r_cnt;
  V32 r_p, r_q, r_d;
  logic [32:0] w_rem_sh, w_diff;
  V32 w_p, w_q, w_d;
  // MUL: r_p accumulates, r_q is the shifting multiplier, r_d the shifting multiplicand.
  // DIV: r_p is the remainder, r_q shifts dividend out and quotient in, r_d is the divisor.
  always_comb begin
    w_rem_sh = {r_p, r_q[31]};
    w_diff = w_rem_sh - {1'b0, r_d};
    w_p = r_div ? (w_diff[32] ? w_rem_sh[31:0] : w_diff[31:0]) : (r_q[0] ? r_p + r_d : r_p);
    w_q = r_div ? {r_q[30:0], ~w_diff[32]} : r_q >> 1;
    w_d = r_div ? r_d : r_d << 1;
    done = r_run && r_cnt == 5'd31;
    result = r_div ? (r_d == '0 ? DIV_ZERO_RESULT : r_q) : r_p;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_run <= 1'b0;
      r_div <= 1'b0;
      r_cnt <= '0;
      r_p <= '0;
      r_q <= '0;
      r_d <= '0;
    end else if (start) begin
      r_run <= 1'b1;
      r_div <= op == DIV;
      r_cnt <= '0;
      r_p <= '0;
      r_q <= a;
      r_d <= b;
    end else if (r_run) begin
      r_run <= ~done;
      r_cnt <= r_cnt + 5'd1;
      r_p <= w_p;
      r_q <= w_q;
      r_d <= w_d;
    end
  end
endmodule

// File: rtl/stage_execute.sv
// stage_execute: execute pipeline stage; single-cycle ALU ops plus iterative MUL/DIV with stall handshake.
module stage_execute
  import stage_execute_pkg::*;
#(
  parameter V32 DIV_ZERO_RESULT = 32'hFFFF_FFFF
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   memory_busy,
  input  t_stage stage_id,
  output logic   execute_busy,
  output t_stage stage_ex
);
  t_state r_state, w_state_nx;
  t_stage r_ex, w_ex_nx;
  logic w_md, w_start, w_done;
  V32 w_md_result;
  iter_muldiv #(.DIV_ZERO_RESULT(DIV_ZERO_RESULT)) u_iter (
    .clock(clock),
    .reset(reset),
    .start(w_start),
    .op(stage_id.operation),
    .a(stage_id.v1),
    .b(stage_id.v2),
    .done(w_done),
    .result(w_md_result)
  );
  assign stage_ex = r_ex;
  always_comb begin
    w_md = is_muldiv(stage_id.operation);
    w_start = r_state == S_IDLE && w_md && !memory_busy;
    execute_busy = memory_busy || (w_md && r_state != S_DONE) || (r_state == S_DONE && memory_busy);
    w_state_nx = r_state == S_IDLE ? (w_start ? S_ITER : S_IDLE) :
                 r_state == S_ITER ? (w_done ? S_DONE : S_ITER) :
                 (memory_busy ? S_DONE : S_IDLE);
    w_ex_nx = stage_id;
    w_ex_nx.result = r_state == S_DONE ? w_md_result : alu(stage_id.operation, stage_id.v1, stage_id.v2);
    // The memory stage still reads stage_ex while it is busy, so it must not move.
    if (memory_busy)
      w_ex_nx = r_ex;
    else if (r_state == S_ITER || (r_state == S_IDLE && (w_md || stage_id.operation == NOP)))
      w_ex_nx = BUBBLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ex <= BUBBLE;
    end else begin
      r_state <= w_state_nx;
      r_ex <= w_ex_nx;
    end
  end
endmodule

// File: tb/tb_stage_execute.sv
// tb_stage_execute: randomized + directed check of stage_execute against a countdown/arithmetic reference.
module tb_stage_execute;
  import stage_execute_pkg::*;
  logic clock, reset, memory_busy, execute_busy;
  t_stage stage_id, stage_ex;
  int n_chk, n_fail;
  int md_left;
  t_stage exp_ex;
  logic last_busy;

  stage_execute dut (
    .clock(clock),
    .reset(reset),
    .memory_busy(memory_busy),
    .stage_id(stage_id),
    .execute_busy(execute_busy),
    .stage_ex(stage_ex)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic V32 ref_result(input t_stage s);
    logic [63:0] p;
    p = 64'(s.v1) * 64'(s.v2);
    case (s.operation)
      ADD: return s.v1 + s.v2;
      SUB: return s.v1 - s.v2;
      AND: return s.v1 & s.v2;
      OR:  return s.v1 | s.v2;
      XOR: return s.v1 ^ s.v2;
      SHL: return s.v1 << s.v2[4:0];
      SHR: return s.v1 >> s.v2[4:0];
      MUL: return p[31:0];
      DIV: return s.v2 == 0 ? 32'hFFFF_FFFF : s.v1 / s.v2;
      default: return 32'd0;
    endcase
  endfunction

  function automatic t_stage mk(input t_operation op, input V32 a, input V32 b);
    t_stage s;
    s.operation = op;
    s.v1 = a;
    s.v2 = b;
    s.result = $urandom;
    return s;
  endfunction

  // One clock: drive inputs, check busy before the edge, advance the reference, check stage_ex after it.
  task automatic step(input t_stage id, input logic mb, input logic rst);
    logic md, exp_busy;
    stage_id = id;
    memory_busy = mb;
    reset = rst;
    md = id.operation == MUL || id.operation == DIV;
    #1;
    exp_busy = mb || (md && md_left != 0) || (md_left == 0 && mb);
    chk("execute_busy", 128'(execute_busy), 128'(exp_busy));
    last_busy = execute_busy;
    @(posedge clock);
    if (rst) begin
      exp_ex = '0;
      md_left = -1;
    end else if (md_left > 0) begin
      md_left--;
      if (!mb) exp_ex = '0;
    end else if (md_left == 0) begin
      if (!mb) begin
        exp_ex = id;
        exp_ex.result = ref_result(id);
        md_left = -1;
      end
    end else if (!mb) begin
      if (md) begin
        exp_ex = '0;
        md_left = 32;
      end else if (id.operation == NOP) exp_ex = '0;
      else begin
        exp_ex = id;
        exp_ex.result = ref_result(id);
      end
    end
    #1;
    chk("stage_ex", 128'(stage_ex), 128'(exp_ex));
    @(negedge clock);
  endtask

  // Hold an instruction until the stage accepts it (busy low at an edge).
  task automatic issue(input t_stage id, input int pct, output int busy_n, output int edges);
    busy_n = 0;
    edges = 0;
    do begin
      step(id, 1'($urandom_range(99) < pct), 1'b0);
      edges++;
      if (last_busy) busy_n++;
    end while (last_busy && edges < 300);
    if (last_busy) chk("issue_timeout", 128'(edges), 128'(0));
  endtask

  initial begin
    int bn, ed, r1, r2;
    t_stage d, saved;
    V32 a, b;
    n_chk = 0;
    n_fail = 0;
    md_left = -1;
    exp_ex = '0;
    stage_id = '0;
    memory_busy = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    chk("reset_bubble", 128'(stage_ex), 128'(0));

    issue(mk(ADD, 32'hFFFF_FFFF, 32'd2), 0, bn, ed);
    chk("add_result", 128'(stage_ex.result), 128'(32'd1));
    chk("add_busy_cycles", 128'(bn), 128'(0));

    issue(mk(MUL, 32'h0001_0003, 32'h0000_0005), 0, bn, ed);
    chk("mul_result", 128'(stage_ex.result), 128'(32'h0005_000F));
    chk("mul_busy_cycles", 128'(bn), 128'(33));
    chk("mul_latency", 128'(ed), 128'(34));

    issue(mk(DIV, 32'd100, 32'd7), 0, bn, ed);
    chk("div_result", 128'(stage_ex.result), 128'(32'd14));
    chk("div_latency", 128'(ed), 128'(34));

    issue(mk(DIV, 32'd5, 32'd0), 0, bn, ed);
    chk("div0_result", 128'(stage_ex.result), 128'(32'hFFFF_FFFF));
    chk("div0_latency", 128'(ed), 128'(34));

    issue(mk(WRL, 32'h0000_1234, 32'h0000_5678), 0, bn, ed);
    chk("wrl_result", 128'(stage_ex.result), 128'(0));
    saved = stage_ex;
    d = mk(ADD, 32'd3, 32'd4);
    repeat (4) begin
      step(d, 1'b1, 1'b0);
      chk("wrl_hold", 128'(stage_ex), 128'(saved));
    end
    issue(d, 0, bn, ed);
    chk("after_hold_add", 128'(stage_ex.result), 128'(32'd7));

    d = mk(MUL, 32'd7, 32'd9);
    repeat (33) step(d, 1'b0, 1'b0);
    repeat (3) step(d, 1'b1, 1'b0);
    chk("mul_stall_bubble", 128'(stage_ex), 128'(0));
    step(d, 1'b0, 1'b0);
    chk("mul_stall_busy", 128'(last_busy), 128'(0));
    chk("mul_stall_result", 128'(stage_ex.result), 128'(32'd63));

    d = mk(DIV, 32'd1000, 32'd3);
    repeat (11) step(d, 1'b0, 1'b0);
    step(d, 1'b0, 1'b1);
    chk("rst_mid_bubble", 128'(stage_ex), 128'(0));
    step('0, 1'b0, 1'b0);
    chk("rst_mid_busy", 128'(last_busy), 128'(0));

    repeat (300) begin
      r1 = $urandom_range(3);
      r2 = $urandom_range(3);
      a = r1 == 0 ? 32'd0 : r1 == 1 ? 32'hFFFF_FFFF : V32'($urandom);
      b = r2 == 0 ? 32'd0 : r2 == 1 ? 32'hFFFF_FFFF : r2 == 2 ? V32'($urandom_range(40)) : V32'($urandom);
      d = mk(t_operation'($urandom_range(11)), a, b);
      if (d.operation == NOP) d = '0;
      issue(d, 25, bn, ed);
    end
    repeat (3) step('0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
